nikhilum_divider: RTL and testbench
===================================

# nikhilum_divider

Sequential unsigned divider: an 8-bit dividend divided by a 4-bit divisor yields an 8-bit quotient and a 4-bit remainder. It is the inverse datapath to the 4x4 Nikhilam multiplier: it undoes an 8-bit product back into its factor and residue. Trial subtraction is performed as addition of the divisor's two's complement, matching the multiplier's complement-based arithmetic. The block sits behind a valid/ready request channel and drives a valid/ready result channel.

## Interface

Parameters:

- `DIVIDEND_W`, default 8: dividend and quotient width.
- `DIVISOR_W`, default 4: divisor and remainder width.

Ports:

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  high only in IDLE.
- `dividend`  in  DIVIDEND_W  numerator; captured on accept.
- `divisor`  in  DIVISOR_W  denominator; captured on accept.
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  result consumed.
- `quotient`  out  DIVIDEND_W  result quotient.
- `remainder`  out  DIVISOR_W  result remainder.
- `div_zero`  out  1  captured divisor was 0.

## Operation

- The FSM has three states: IDLE, CALC, DONE. Reset sets state to IDLE, `quotient`, `remainder` and `div_zero` to 0, and `out_valid` to 0. `in_ready` is 1 after reset.
- **Accept.** In IDLE, `in_valid && in_ready` at an edge does the following:
  - captures the dividend into shift register Q and the divisor into D;
  - clears partial remainder R (DIVISOR_W+1 bits);
  - clears the bit counter;
  - moves to CALC.
- **CALC iteration** (one per cycle, dividend MSB first):
  - S = {R[DIVISOR_W-1:0], Q[MSB]}.
  - T = {1'b0,S} + (~{2'b0,D} + 1), computed in DIVISOR_W+2 bits.
  - If T[MSB]==0: R = T[DIVISOR_W:0] and the quotient bit is 1. Otherwise R = S and the quotient bit is 0.
  - Q shifts left and the quotient bit enters the LSB.
- After DIVIDEND_W iterations the FSM moves to DONE.
  - `quotient` = Q.
  - `remainder` = R[DIVISOR_W-1:0].
  - `div_zero` = (D==0).
- **Invariants.** R < 2·D before each shift, so DIVISOR_W+1 bits never overflow. The result always satisfies quotient·divisor + remainder == dividend, and remainder < divisor when divisor≠0.
- **Divisor 0.** Every trial succeeds.
  - `quotient` = all ones (8'hFF).
  - `remainder` = dividend[DIVISOR_W-1:0].
  - `div_zero` = 1.
- **DONE.** `out_valid` is held at 1 and all outputs are stable until `out_ready` is 1 at an edge; the FSM then returns to IDLE. No new request is accepted in that same cycle.
- `in_valid` in CALC or DONE is ignored, and the input buses are not sampled.
- `quotient`, `remainder` and `div_zero` keep their last values in IDLE and CALC. They update only on entry to DONE.
- **Reset mid-operation** (rst=1 in any state) aborts the division. The FSM goes to IDLE and all outputs take their reset values. No partial result is ever presented.

## Timing

- Request accepted at edge N: CALC iterations occur at edges N+1 … N+DIVIDEND_W.
- `out_valid` rises after edge N+DIVIDEND_W (8 cycles for the defaults).
- Minimum throughput: one division per DIVIDEND_W+2 cycles (accept, 8 CALC, 1 DONE handshake).
- `in_ready` and `out_valid` are decoded from state only. Neither has a combinational path from `in_valid` or `out_ready`.
- `rst` has priority over every handshake at the same edge.

## Configuration

- Macro: `NIKHILUM_DIV_FAST_ZERO_EN`.
- **Defined:** an accept with divisor==0 skips CALC and goes directly to DONE, so `out_valid` rises after edge N+1. Values are `quotient`=8'hFF, `remainder`=dividend[3:0], `div_zero`=1.
- **Undefined:** divisor 0 runs all DIVIDEND_W iterations. The outputs are identical and only the latency differs.
- Nonzero divisors behave identically in both builds.

## Test plan

- **Basic divide.** 200/7 → `quotient`=28 (0x1C), `remainder`=4, `div_zero`=0, `out_valid` exactly 8 cycles after accept. 255/15 → 17, 0.
- **Dividend smaller than divisor.** 5/9 → `quotient`=0, `remainder`=5. 0/3 → 0, 0.
- **Divide by zero.** 0x96/0 → `quotient`=0xFF, `remainder`=6, `div_zero`=1. Latency is 8 cycles without the macro and 1 with it.
- **Backpressure and busy.**
  - Hold `out_ready`=0 for 5 cycles in DONE: outputs and `out_valid` stay stable.
  - Pulse `in_valid` with 99/3 during CALC and DONE: it is ignored, `in_ready`=0, and the original result is unchanged.
- **Reset mid-CALC.** Assert `rst` at iteration 4 of 200/7: next cycle IDLE, `out_valid`=0, outputs 0, `in_ready`=1. A following 100/10 gives 10, 0.
- **Exhaustive.** All 256×16 operand pairs with random `out_ready` stalls: quotient·divisor + remainder == dividend and remainder < divisor for divisor≠0. The divisor-0 rule above holds otherwise.

Source files
------------

// File: rtl/nikhilum_divider.sv
`timescale 1ns/1ps
// nikhilum_divider: sequential unsigned restoring divider with valid/ready request and result channels.
// Optional macro NIKHILUM_DIV_FAST_ZERO_EN: a zero divisor bypasses the iterations and reaches DONE one cycle after accept.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | one quotient bit per cycle, dividend MSB first
// DONE  | result held, out_valid high until out_ready
module nikhilum_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  localparam int TW    = DIVISOR_W + 2;
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_d;
  logic [DIVISOR_W:0]    r_r;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_div_zero;

  logic [DIVISOR_W:0]    w_s;
  logic [TW-1:0]         w_neg_d;
  logic [TW-1:0]         w_t;
  logic                  w_qbit;
  logic [DIVISOR_W:0]    w_r_next;
  logic [DIVIDEND_W-1:0] w_q_next;
  logic                  w_accept;

  // Trial subtraction done as addition of the divisor's two's complement; a clear MSB means no borrow.
  assign w_s      = {r_r[DIVISOR_W-1:0], r_q[DIVIDEND_W-1]};
  assign w_neg_d  = ~{2'b00, r_d} + TW'(1);
  assign w_t      = {1'b0, w_s} + w_neg_d;
  assign w_qbit   = ~w_t[TW-1];
  assign w_r_next = w_qbit ? w_t[DIVISOR_W:0] : w_s;
  assign w_q_next = {r_q[DIVIDEND_W-2:0], w_qbit};

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_q     <= dividend;
            r_d     <= divisor;
            r_r     <= '0;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
`ifdef NIKHILUM_DIV_FAST_ZERO_EN
          // Q still holds the untouched dividend here, so its low bits are the remainder.
          if (r_d == '0) begin
            r_quotient  <= '1;
            r_remainder <= r_q[DIVISOR_W-1:0];
            r_div_zero  <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_q   <= w_q_next;
            r_r   <= w_r_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
              r_quotient  <= w_q_next;
              r_remainder <= w_r_next[DIVISOR_W-1:0];
              r_div_zero  <= 1'b0;
              r_state     <= S_DONE;
            end
          end
`else
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next[DIVISOR_W-1:0];
            r_div_zero  <= (r_d == '0);
            r_state     <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nikhilum_divider.sv
`timescale 1ns/1ps
// tb_nikhilum_divider: directed and randomized checks of nikhilum_divider against an arithmetic reference.
module tb_nikhilum_divider;

`ifdef NIKHILUM_DIV_FAST_ZERO_EN
  localparam bit FAST_ZERO = 1'b1;
`else
  localparam bit FAST_ZERO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nikhilum_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [3:0] b);
    return (b == 4'd0) ? 8'hFF : 8'(a / b);
  endfunction

  function automatic logic [3:0] ref_r(input logic [7:0] a, input logic [3:0] b);
    return (b == 4'd0) ? a[3:0] : 4'(a % b);
  endfunction

  function automatic int ref_lat(input logic [3:0] b);
    return (FAST_ZERO && b == 4'd0) ? 1 : 8;
  endfunction

  task automatic do_div(input logic [7:0] a, input logic [3:0] b, input int stall);
    int lat;
    logic [7:0] eq;
    logic [3:0] er;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    check("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, ref_lat(b));
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", div_zero, (b == 4'd0));
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_quotient", quotient, eq);
      check("stall_remainder", remainder, er);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("released_valid", out_valid, 0);
    check("released_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] a;
    logic [3:0] b;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) tick();
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    do_div(8'd200, 4'd7, 0);
    check("200/7_q", quotient, 8'h1C);
    do_div(8'd255, 4'd15, 0);
    do_div(8'd5, 4'd9, 0);
    do_div(8'd0, 4'd3, 0);
    do_div(8'h96, 4'd0, 0);
    check("div0_rem", remainder, 4'd6);
    do_div(8'd123, 4'd11, 5);

    // Busy: new requests offered throughout CALC and DONE must be ignored.
    in_valid = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    tick();
    dividend = 8'd99;
    divisor  = 4'd3;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      if (!out_valid) check("busy_in_ready", in_ready, 0);
    end
    check("busy_latency", lat, 8);
    check("busy_quotient", quotient, 8'd28);
    check("busy_remainder", remainder, 4'd4);
    tick();
    check("busy_done_valid", out_valid, 1);
    check("busy_done_quotient", quotient, 8'd28);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("busy_release_valid", out_valid, 0);
    check("busy_release_quotient", quotient, 8'd28);
    tick();
    check("busy_no_accept", in_ready, 1);

    // Reset during the fourth CALC iteration.
    in_valid = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_div_zero", div_zero, 0);
    check("midrst_in_ready", in_ready, 1);
    do_div(8'd100, 4'd10, 0);
    check("100/10_q", quotient, 8'd10);

    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = 4'($urandom);
      do_div(a, b, $urandom_range(0, 3));
    end

    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 16; y++) begin
        do_div(8'(x), 4'(y), $urandom_range(0, 2));
        if (y != 0) begin
          check("invariant", int'(quotient) * y + int'(remainder), x);
          check("rem_lt_divisor", int'(remainder) < y, 1);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
